// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing and types for the register scoreboard.
// The optional macro SCB_WB_BYPASS_EN is consumed by reg_scoreboard only.
package reg_scoreboard_pkg;

  localparam int NREG  = 16;
  localparam int RID_W = 4;
  localparam int CNT_W = 2;
  localparam int INF_W = RID_W + CNT_W;

  typedef logic [RID_W-1:0] rid_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

  // Zero-extend a counter value to the inflight-sum width.
  function automatic logic [INF_W-1:0] cnt_ext(input cnt_t c);
    return {{RID_W{1'b0}}, c};
  endfunction

endpackage

// File: rtl/reg_scoreboard_cnt_cell.sv
// One pending-write counter: +inc -dec -dec2 in a single update, clamped
// at zero (flagging underflow) and at CNT_MAX.
module scb_cnt_cell
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic dec2,
  output cnt_t count,
  output cnt_t cnt_nxt,
  output logic underflow
);

  logic [CNT_W:0] up_s;
  logic [CNT_W:0] down_s;
  logic [CNT_W:0] diff_s;

  // Net-delta arithmetic with clamping at both ends.
  always_comb begin
    up_s      = {1'b0, count} + {{CNT_W{1'b0}}, inc};
    down_s    = {{CNT_W{1'b0}}, dec} + {{CNT_W{1'b0}}, dec2};
    diff_s    = {(CNT_W+1){1'b0}};
    cnt_nxt   = {CNT_W{1'b0}};
    underflow = 1'b0;
    if (up_s < down_s) begin
      underflow = 1'b1;
      cnt_nxt   = {CNT_W{1'b0}};
    end else begin
      diff_s = up_s - down_s;
      if (diff_s > {1'b0, CNT_MAX}) begin
        cnt_nxt = CNT_MAX;
      end else begin
        cnt_nxt = diff_s[CNT_W-1:0];
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= {CNT_W{1'b0}};
    end else begin
      count <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard producing the ID-stage stall.
// Define SCB_WB_BYPASS_EN to let a same-cycle write-back relieve hazards.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_wb_en,
  input  logic [RID_W-1:0] issue_dest,
  input  logic [RID_W-1:0] src1,
  input  logic [RID_W-1:0] src2,
  input  logic             two_src,
  input  logic             wb_valid,
  input  logic [RID_W-1:0] wb_dest,
  input  logic             kill_valid,
  input  logic [RID_W-1:0] kill_dest,
  output logic             stall,
  output logic [NREG-1:0]  pending,
  output logic [INF_W-1:0] inflight,
  output logic             err
);

  cnt_t             cnt_s   [NREG];
  cnt_t             nxt_s   [NREG];
  logic [NREG-1:0]  inc_s;
  logic [NREG-1:0]  dec_s;
  logic [NREG-1:0]  dec2_s;
  logic [NREG-1:0]  uf_s;
  logic [NREG-1:0]  pend_nxt_s;
  logic [INF_W-1:0] inflight_nxt_s;
  logic             hz1_s;
  logic             hz2_s;
  logic             sat_s;
  logic             accept_s;

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_cell
      assign inc_s[g]  = accept_s && issue_wb_en && (issue_dest == rid_t'(g));
      assign dec_s[g]  = wb_valid && (wb_dest == rid_t'(g));
      assign dec2_s[g] = kill_valid && (kill_dest == rid_t'(g));

      scb_cnt_cell u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc_s[g]),
        .dec       (dec_s[g]),
        .dec2      (dec2_s[g]),
        .count     (cnt_s[g]),
        .cnt_nxt   (nxt_s[g]),
        .underflow (uf_s[g])
      );
    end
  endgenerate

  // Hazard and saturation terms; the instruction is accepted only without stall.
  always_comb begin
    hz1_s = (cnt_s[src1] != {CNT_W{1'b0}});
    hz2_s = two_src && (cnt_s[src2] != {CNT_W{1'b0}});
    sat_s = issue_wb_en && (cnt_s[issue_dest] == CNT_MAX);
`ifdef SCB_WB_BYPASS_EN
    // A last pending writer retiring this cycle is visible to ID already.
    if ((cnt_s[src1] == cnt_t'(1)) && wb_valid && (wb_dest == src1)) begin
      hz1_s = 1'b0;
    end else begin
      hz1_s = hz1_s;
    end
    if ((cnt_s[src2] == cnt_t'(1)) && wb_valid && (wb_dest == src2)) begin
      hz2_s = 1'b0;
    end else begin
      hz2_s = hz2_s;
    end
    if (wb_valid && (wb_dest == issue_dest)) begin
      sat_s = 1'b0;
    end else begin
      sat_s = sat_s;
    end
`endif
    stall    = issue_valid && (hz1_s || hz2_s || sat_s);
    accept_s = issue_valid && !stall;
  end

  // Next-state summaries for the registered outputs.
  always_comb begin
    inflight_nxt_s = {INF_W{1'b0}};
    pend_nxt_s     = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      inflight_nxt_s = inflight_nxt_s + cnt_ext(nxt_s[i]);
      pend_nxt_s[i]  = (nxt_s[i] != {CNT_W{1'b0}});
    end
  end

  // Output registers; err is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= {NREG{1'b0}};
      inflight <= {INF_W{1'b0}};
      err      <= 1'b0;
    end else begin
      pending  <= pend_nxt_s;
      inflight <= inflight_nxt_s;
      err      <= err || (|uf_s);
    end
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side companion to the pipeline hazard detector. Tracks pending register writes per architectural register, from issue (ID stage) until write-back (WB stage) or squash.
- Produces a stall when a source operand still has an in-flight writer, or when a destination's pending count is saturated.
- Replaces comparator-based hazard detection on per-stage dest fields with per-register counters. This decouples hazard checking from pipeline depth and from multi-cycle memory stalls.

Parameters:
- NREG, 16, number of architectural registers tracked (register IDs are 0..NREG-1).
- RID_W, 4, register ID width (clog2 of NREG).
- CNT_W, 2, per-register pending-write counter width; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- issue_valid  in  1  ID stage presents an instruction this cycle.
- issue_wb_en  in  1  issuing instruction writes a register.
- issue_dest  in  RID_W  destination register of issuing instruction.
- src1  in  RID_W  first source register.
- src2  in  RID_W  second source register.
- two_src  in  1  src2 is a real operand.
- wb_valid  in  1  WB stage retires a register write this cycle.
- wb_dest  in  RID_W  register being written back.
- kill_valid  in  1  a squashed in-flight instruction with wb_en is dropped (one per cycle).
- kill_dest  in  RID_W  destination of the squashed instruction.
- stall  out  1  combinational; ID must hold; the instruction is not accepted.
- pending  out  NREG  registered; bit r = (count[r] != 0).
- inflight  out  RID_W+CNT_W  registered total of pending writes across all registers.
- err  out  1  registered sticky error flag.

Behaviour:
- Reset (rst_n=0 at a clock edge): all count[r]=0, pending=0, inflight=0, err=0. Reset overrides every other event in that cycle. Reset mid-operation discards all tracking; the pipeline is flushed externally in the same cycle.
- Combinational stall terms:
  - hz1 = count[src1]!=0.
  - hz2 = two_src && count[src2]!=0.
  - sat = issue_wb_en && count[issue_dest]==2^CNT_W-1.
  - stall = issue_valid && (hz1 || hz2 || sat).
- stall is 0 whenever issue_valid=0.
- accept = issue_valid && !stall. An accepted instruction with issue_wb_en=1 increments count[issue_dest] at the next edge (1-cycle latency). Its own src/dest overlap (e.g. r1=r1+r2) is legal.
- Per register r, net delta = +accept_inc(r) - wb_dec(r) - kill_dec(r), applied in a single update. Simultaneous issue, wb and kill on the same register combine arithmetically: count 1 with issue+wb gives 1; count 2 with wb+kill gives 0.
- Underflow: a decrement that would take count below 0 leaves count at 0 and sets err=1. This covers wb/kill on count 0, and wb+kill on the same register with count 1.
- err stays set until reset.
- inflight = sum of all counts. It is updated with the same edge as the counts and never wraps, since its width covers NREG*(2^CNT_W-1).
- Source reads of a register retiring this cycle still stall, because the register file is written at the clock edge (default build).
- No internal FSM beyond the counter array. Stall is held, not pulsed; ID re-presents the same instruction until stall=0.

Optional Feature:
- Macro SCB_WB_BYPASS_EN.
- Defined: a source hazard is suppressed when count[src]==1 && wb_valid && wb_dest==src (write-first register file or WB→ID forwarding). sat is similarly relieved when wb_valid && wb_dest==issue_dest.
- Undefined: exact equations above; no same-cycle relief.

Decomposition:
- Shared package holds NREG, RID_W, CNT_W defaults, a register-ID typedef and a counter typedef.
- One natural sub-module, scb_cnt_cell: a single saturating up/down counter with inc, dec, dec2 and underflow flag. Instantiate NREG times; the top holds decode, stall logic, inflight summation and err.

Test Plan:
- Reset: rst_n=0 with issue_valid=1, wb_en=1, dest=3 -> next cycle pending=0, inflight=0, err=0.
- RAW stall: issue dest=2 (accepted); next cycle issue src1=2 -> stall=1. wb_valid dest=2 -> stall drops the cycle after retire (default build). Same cycle as retire with SCB_WB_BYPASS_EN defined.
- two_src gating: count[5]=1, src2=5, two_src=0 -> stall=0; two_src=1 -> stall=1.
- Saturation: three accepted issues to dest=7 (CNT_W=2) -> count=3; fourth issue with wb_en=1 to dest 7 -> stall=1, count stays 3.
- Simultaneous events: count[4]=2, issue dest=4, wb dest=4 and kill dest=4 in the same cycle -> count[4]=1, inflight decreases by 1.
- Underflow: count[9]=0, wb_valid dest=9 -> count[9]=0, err=1, and err stays 1 until rst_n=0.
